// File: rtl/player_collision_hp.sv
// Player square collision, hit points and invulnerability for the pixel stream.
// Optional PLAYER_BLINK_EN: blink the player every 8 frames while invulnerable.
module player_collision_hp #(
  parameter int          PLAYER_SIZE   = 16,
  parameter logic [11:0] PLAYER_COLOR  = 12'hfff,
  parameter logic [11:0] BG_COLOR      = 12'h000,
  parameter int          HP_MAX        = 3,
  parameter int          INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        game_on,
  input  logic        play_selected,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [3:0]  hp,
  output logic        hit,
  output logic        invulnerable,
  output logic        defeat
);

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, DEAD} state_t;

  localparam logic [12:0] SZ   = 13'(PLAYER_SIZE);
  localparam logic [3:0]  HPM  = 4'(HP_MAX);
  localparam logic [7:0]  INVF = 8'(INVULN_FRAMES);

  state_t      state_q, state_d;
  logic [7:0]  inv_cnt;
  logic        ovl_flag;
  logic        load, dmg, kill;
  logic        draw_ok, blink_ok;
  logic        frame_end, in_player, ovl_now, dmg_now;
  logic [12:0] hx, vy, px, py;

  // 13-bit compare keeps the square from wrapping past the screen edge
  assign hx = {1'b0, hcount_in};
  assign vy = {1'b0, vcount_in};
  assign px = {1'b0, xpos};
  assign py = {1'b0, ypos};

  assign in_player = (hx >= px) && (hx < px + SZ) &&
                     (vy >= py) && (vy < py + SZ) &&
                     !hblnk_in && !vblnk_in;

  assign ovl_now   = in_player && (rgb_in != BG_COLOR);
  assign frame_end = vsync_in && !vsync_out;
  assign dmg_now   = frame_end && (ovl_flag || ovl_now);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dmg     = 1'b0;
    kill    = 1'b0;
    if (!game_on) begin
      state_d = IDLE;
    end else if (play_selected) begin
      state_d = PLAY;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (dmg_now) begin
            dmg     = 1'b1;
            kill    = (hp <= 4'd1);
            state_d = kill ? DEAD : INVULN;
          end
        end
        INVULN: begin
          if (frame_end && inv_cnt <= 8'd1) state_d = PLAY;
        end
        IDLE, DEAD: state_d = state_q;
      endcase
    end
  end

`ifdef PLAYER_BLINK_EN
  logic [2:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)            frame_cnt <= 3'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 3'd1;
  end

  assign blink_ok = !frame_cnt[2];
`else
  assign blink_ok = 1'b1;
`endif

  always_comb begin
    invulnerable = (state_q == INVULN);
    draw_ok      = (state_q == PLAY) ||
                   ((state_q == INVULN) && blink_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp       <= 4'd0;
      hit      <= 1'b0;
      defeat   <= 1'b0;
      inv_cnt  <= 8'd0;
      ovl_flag <= 1'b0;
    end else begin
      hit    <= dmg;
      defeat <= kill;
      if (load) begin
        hp       <= HPM;
        inv_cnt  <= 8'd0;
        ovl_flag <= 1'b0;
      end else if (!game_on) begin
        inv_cnt  <= 8'd0;
        ovl_flag <= 1'b0;
      end else begin
        // overlap on the frame_end cycle is already folded into dmg_now
        if (frame_end)
          ovl_flag <= 1'b0;
        else if (state_q == PLAY && ovl_now)
          ovl_flag <= 1'b1;
        if (dmg) begin
          hp      <= kill ? 4'd0 : hp - 4'd1;
          inv_cnt <= INVF;
        end else if (state_q == INVULN && frame_end && inv_cnt != 8'd0) begin
          inv_cnt <= inv_cnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= (in_player && draw_ok) ? PLAYER_COLOR : rgb_in;
    end
  end

endmodule

// File: tb/tb_player_collision_hp.sv
// Directed bench for player_collision_hp: pixel vectors plus damage sequences.
module tb_player_collision_hp;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, rgb_in, xpos, ypos;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        game_on, play_selected;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [3:0]  hp;
  logic        hit, invulnerable, defeat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  player_collision_hp dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .game_on(game_on), .play_selected(play_selected),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hp(hp), .hit(hit),
    .invulnerable(invulnerable), .defeat(defeat)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] c;
    logic [11:0] exp_rgb;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v,
                     input logic [11:0] c, input logic hb, input logic vb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hb;
    vsync_in  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(output logic h, output logic d);
    hcount_in = 12'd0;
    vcount_in = 12'd0;
    rgb_in    = 12'h000;
    hblnk_in  = 1'b1;
    vblnk_in  = 1'b1;
    vsync_in  = 1'b1;
    @(posedge clk);
    #1;
    h = hit;
    d = defeat;
  endtask

  task automatic restart();
    pix(12'd0, 12'd0, 12'h000, 1'b1, 1'b1);
    play_selected = 1'b1;
    game_on       = 1'b1;
    pix(12'd0, 12'd0, 12'h000, 1'b1, 1'b1);
    play_selected = 1'b0;
  endtask

  logic h, d;
  int   hits, vis;

  initial begin
    //       x      h      v     hb    vb    c        rgb_out  hit
    vecs[0] = '{12'd100, 12'd100, 12'd100, 1'b0, 1'b0, 12'h000, 12'hfff, 1'b0};
    vecs[1] = '{12'd100, 12'd105, 12'd108, 1'b0, 1'b0, 12'h0f0, 12'hfff, 1'b1};
    vecs[2] = '{12'd100, 12'd116, 12'd108, 1'b0, 1'b0, 12'h0f0, 12'h0f0, 1'b0};
    vecs[3] = '{12'd100, 12'd115, 12'd115, 1'b0, 1'b0, 12'h00f, 12'hfff, 1'b1};
    vecs[4] = '{12'd100, 12'd108, 12'd116, 1'b0, 1'b0, 12'h00f, 12'h00f, 1'b0};
    vecs[5] = '{12'd100, 12'd99,  12'd100, 1'b0, 1'b0, 12'habc, 12'habc, 1'b0};
    vecs[6] = '{12'd100, 12'd105, 12'd108, 1'b1, 1'b0, 12'h0f0, 12'h0f0, 1'b0};
    vecs[7] = '{12'd4090, 12'd2,  12'd100, 1'b0, 1'b0, 12'h0f0, 12'h0f0, 1'b0};
    vecs[8] = '{12'd4090, 12'd4095, 12'd100, 1'b0, 1'b0, 12'h0f0, 12'hfff, 1'b1};

    rst = 1'b1;
    game_on = 1'b0;
    play_selected = 1'b0;
    xpos = 12'd100;
    ypos = 12'd100;
    pix(12'd50, 12'd60, 12'h123, 1'b0, 1'b0);
    pix(12'd50, 12'd60, 12'h123, 1'b0, 1'b0);
    chk("reset_hp", hp, 0);
    chk("reset_hit", hit, 0);
    chk("reset_defeat", defeat, 0);
    chk("reset_invuln", invulnerable, 0);
    chk("reset_rgb", rgb_out, 0);
    chk("reset_hcount", hcount_out, 0);
    rst = 1'b0;

    restart();
    chk("start_hp", hp, 3);

    for (int i = 0; i < 9; i++) begin
      xpos = vecs[i].x;
      restart();
      pix(vecs[i].h, vecs[i].v, vecs[i].c, vecs[i].hb, vecs[i].vb);
      chk($sformatf("vec%0d_rgb", i), rgb_out, vecs[i].exp_rgb);
      chk($sformatf("vec%0d_hcount", i), hcount_out, vecs[i].h);
      frame(h, d);
      chk($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
      chk($sformatf("vec%0d_hp", i), hp, vecs[i].exp_hit ? 2 : 3);
      chk($sformatf("vec%0d_inv", i), invulnerable, vecs[i].exp_hit);
    end

    // invulnerability window with an overlap in every frame
    xpos = 12'd100;
    restart();
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    chk("inv_first_hit", h, 1);
    chk("inv_first_defeat", d, 0);
    hits = 0;
    for (int k = 1; k <= 60; k++) begin
      pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
      frame(h, d);
      if (h) hits++;
      if (k == 59) chk("inv_high_f59", invulnerable, 1);
      if (k == 60) chk("inv_low_f60", invulnerable, 0);
    end
    chk("inv_no_hits", hits, 0);
    chk("inv_hp_hold", hp, 2);
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    chk("resume_hit", h, 1);
    chk("resume_hp", hp, 1);

    // wait out invulnerability, then the lethal hit
    for (int k = 1; k <= 60; k++) begin
      pix(12'd105, 12'd108, 12'h000, 1'b0, 1'b0);
      frame(h, d);
    end
    chk("pre_kill_inv", invulnerable, 0);
    pix(12'd110, 12'd110, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    chk("kill_hit", h, 1);
    chk("kill_defeat", d, 1);
    chk("kill_hp", hp, 0);
    pix(12'd0, 12'd0, 12'h000, 1'b1, 1'b1);
    chk("defeat_pulse_end", defeat, 0);
    pix(12'd100, 12'd100, 12'h000, 1'b0, 1'b0);
    chk("dead_undrawn", rgb_out, 12'h000);
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    chk("dead_no_hit", h, 0);
    chk("dead_hp", hp, 0);
    restart();
    chk("revive_hp", hp, 3);

    // blinking or solid player across 8 invulnerable frames
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    vis = 0;
    for (int k = 0; k < 8; k++) begin
      pix(12'd0, 12'd0, 12'h000, 1'b1, 1'b1);
      pix(12'd100, 12'd100, 12'h000, 1'b0, 1'b0);
      if (rgb_out == 12'hfff) vis++;
      frame(h, d);
    end
`ifdef PLAYER_BLINK_EN
    chk("blink_visible", vis, 4);
`else
    chk("solid_visible", vis, 8);
`endif

    // game_on drop mid-invulnerability
    restart();
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    frame(h, d);
    chk("drop_pre_inv", invulnerable, 1);
    game_on = 1'b0;
    pix(12'd0, 12'd0, 12'h000, 1'b1, 1'b1);
    chk("drop_inv", invulnerable, 0);
    pix(12'd100, 12'd100, 12'h456, 1'b0, 1'b0);
    chk("idle_undrawn", rgb_out, 12'h456);

    // reset mid-frame
    restart();
    pix(12'd105, 12'd108, 12'h0f0, 1'b0, 1'b0);
    rst = 1'b1;
    pix(12'd106, 12'd108, 12'h0f0, 1'b0, 1'b0);
    chk("rst_mid_rgb", rgb_out, 0);
    chk("rst_mid_hcount", hcount_out, 0);
    chk("rst_mid_hp", hp, 0);
    chk("rst_mid_inv", invulnerable, 0);
    rst = 1'b0;
    frame(h, d);
    chk("rst_mid_no_hit", h, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
